// File: rtl/alu_addsub_pipe_if.sv
// rtl/alu_addsub_pipe_if.sv - operand/result handshake bundle for alu_addsub_pipe
//
// Purpose: groups the operand-side and result-side valid/ready channels of the
//          two-stage add/subtract unit.
// Signals:
//   in_valid/in_ready   operand beat handshake
//   in_a/in_b           operands (DATA_W)
//   in_sub              1 = A - B, 0 = A + B
//   in_tag              5-bit destination tag
//   out_valid/out_ready result beat handshake
//   out_sum             result (DATA_W)
//   out_cout/out_ovf    carry out of MSB / signed overflow
//   out_zero            out_sum == 0
//   out_tag             tag of this result
// Modports: master = operand producer and result consumer, slave = the unit.

interface alu_addsub_pipe_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              in_sub;
   logic [4:0]        in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_sum;
   logic              out_cout;
   logic              out_ovf;
   logic              out_zero;
   logic [4:0]        out_tag;

   modport master (
      output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
   );
endinterface

// File: rtl/alu_addsub_pipe.sv
// rtl/alu_addsub_pipe.sv - two-stage pipelined add/subtract unit with group lookahead
//
// Purpose: 32-bit add/subtract split at the half boundary. Stage 1 adds the
//          low half and registers the mid carry plus the upper operands;
//          stage 2 adds the upper half and registers sum and flags.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous, active-low reset
//   bus      alu_addsub_pipe_if.slave (operand and result handshakes)
// Parameters:
//   DATA_W   operand/result width, multiple of 2*GROUP_W
//   GROUP_W  lookahead group width
// Optional feature macro: ALU_ADDSUB_SAT_EN
//   defined   -> signed overflow saturates out_sum to the extreme of a's sign
//   undefined -> out_sum is always the wrapped result

module alu_addsub_pipe #(
   parameter int DATA_W  = 32,
   parameter int GROUP_W = 8
) (
   input logic             clock,
   input logic             reset_n,
   alu_addsub_pipe_if.slave bus
);

   localparam int HALF_W = DATA_W / 2;
   localparam int NGRP   = HALF_W / GROUP_W;

   // Half-width adder: per-bit G/P, per-group G/P, two-level lookahead for
   // the carry into every group, ripple only inside a group.
   // Returns {carry_out, sum}.
   function automatic logic [HALF_W:0] half_add(
      input logic [HALF_W-1:0] a,
      input logic [HALF_W-1:0] b,
      input logic              cin
   );
      logic [HALF_W-1:0] g;
      logic [HALF_W-1:0] p;
      logic [HALF_W-1:0] s;
      logic [NGRP-1:0]   gg;
      logic [NGRP-1:0]   gp;
      logic [NGRP:0]     gc;
      logic              term;
      logic              c;
      g = a & b;
      p = a ^ b;
      s = '0;
      for (int k = 0; k < NGRP; k++) begin
         gg[k] = 1'b0;
         gp[k] = 1'b1;
         for (int j = 0; j < GROUP_W; j++) begin
            gg[k] = g[k*GROUP_W+j] | (p[k*GROUP_W+j] & gg[k]);
            gp[k] = gp[k] & p[k*GROUP_W+j];
         end
      end
      // gc[k] = cin & P[0..k-1]  |  OR_j ( G[j] & P[j+1..k-1] )
      for (int k = 0; k <= NGRP; k++) begin
         gc[k] = cin;
         for (int m = 0; m < k; m++) begin
            gc[k] = gc[k] & gp[m];
         end
         for (int j = 0; j < k; j++) begin
            term = gg[j];
            for (int m = j + 1; m < k; m++) begin
               term = term & gp[m];
            end
            gc[k] = gc[k] | term;
         end
      end
      for (int k = 0; k < NGRP; k++) begin
         c = gc[k];
         for (int j = 0; j < GROUP_W; j++) begin
            s[k*GROUP_W+j] = p[k*GROUP_W+j] ^ c;
            c = g[k*GROUP_W+j] | (p[k*GROUP_W+j] & c);
         end
      end
      return {gc[NGRP], s};
   endfunction

   // Stage-1 state
   logic              s1_valid;
   logic [HALF_W-1:0] s1_sum_lo;
   logic              s1_c_mid;
   logic [HALF_W-1:0] s1_a_hi;
   logic [HALF_W-1:0] s1_b_hi;
   logic [4:0]        s1_tag;

   // Output registers
   logic              o_valid;
   logic [DATA_W-1:0] o_sum;
   logic              o_cout;
   logic              o_ovf;
   logic              o_zero;
   logic [4:0]        o_tag;

   logic adv1;
   logic adv2;

   assign adv2 = ~o_valid | bus.out_ready;
   assign adv1 = ~s1_valid | adv2;

   // Stage-1 combinational: operand prep and low-half add
   logic [DATA_W-1:0] b_eff;
   logic [HALF_W:0]   lo_res;

   assign b_eff  = bus.in_sub ? ~bus.in_b : bus.in_b;
   assign lo_res = half_add(bus.in_a[HALF_W-1:0], b_eff[HALF_W-1:0], bus.in_sub);

   // Stage-2 combinational: high-half add from registered operands and flags
   logic [HALF_W:0]   hi_res;
   logic [DATA_W-1:0] sum_wrap;
   logic              a_msb;
   logic              b_msb;
   logic              ovf;
   logic [DATA_W-1:0] sum_fin;

   assign hi_res   = half_add(s1_a_hi, s1_b_hi, s1_c_mid);
   assign sum_wrap = {hi_res[HALF_W-1:0], s1_sum_lo};
   assign a_msb    = s1_a_hi[HALF_W-1];
   assign b_msb    = s1_b_hi[HALF_W-1];
   assign ovf      = (a_msb == b_msb) && (sum_wrap[DATA_W-1] != a_msb);

`ifdef ALU_ADDSUB_SAT_EN
   // Saturate toward the sign of a: both operands share that sign on overflow.
   assign sum_fin = !ovf ? sum_wrap :
                    a_msb ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
   assign sum_fin = sum_wrap;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s1_sum_lo <= '0;
         s1_c_mid  <= 1'b0;
         s1_a_hi   <= '0;
         s1_b_hi   <= '0;
         s1_tag    <= '0;
         o_valid   <= 1'b0;
         o_sum     <= '0;
         o_cout    <= 1'b0;
         o_ovf     <= 1'b0;
         o_zero    <= 1'b0;
         o_tag     <= '0;
      end else begin
         if (adv2) begin
            o_valid <= s1_valid;
            // Payload only moves with a real beat so a stalled/idle output holds.
            if (s1_valid) begin
               o_sum  <= sum_fin;
               o_cout <= hi_res[HALF_W];
               o_ovf  <= ovf;
               o_zero <= ~|sum_fin;
               o_tag  <= s1_tag;
            end
         end
         if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_sum_lo <= lo_res[HALF_W-1:0];
               s1_c_mid  <= lo_res[HALF_W];
               s1_a_hi   <= bus.in_a[DATA_W-1:HALF_W];
               s1_b_hi   <= b_eff[DATA_W-1:HALF_W];
               s1_tag    <= bus.in_tag;
            end
         end
      end
   end

   assign bus.in_ready  = adv1;
   assign bus.out_valid = o_valid;
   assign bus.out_sum   = o_sum;
   assign bus.out_cout  = o_cout;
   assign bus.out_ovf   = o_ovf;
   assign bus.out_zero  = o_zero;
   assign bus.out_tag   = o_tag;

endmodule
